branch_pc_unit: RTL and testbench

- Program-counter and next-PC unit for the single-cycle MIPS core.
- Consumes the ALU's 2-bit sign/zero flag (zero) to resolve conditional branches.
- Also resolves j/jal/jr redirects and holds the architectural PC register that addresses instruction memory.
- Sits between the controller/ALU outputs and IM; drives pc, the link value for jal, and a sticky misalignment error.

---
 rtl/branch_pc_unit.sv | 131 +++++++++++++
 tb/tb_branch_pc_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter and next-PC resolution for the single-cycle MIPS core.
// Optional macro BRANCH_DELAY_SLOT_EN delays every redirect by one instruction (delay slot).
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  br_type,
    input  logic [1:0]  zero,
    input  logic [15:0] imm16,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        branch_taken,
    output logic        misalign_err
);

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLEZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;
    localparam logic [2:0] BR_J    = 3'b110;
    localparam logic [2:0] BR_JR   = 3'b111;

    localparam logic [1:0] FLAG_NEG  = 2'b00;
    localparam logic [1:0] FLAG_ZERO = 2'b01;
    localparam logic [1:0] FLAG_POS  = 2'b10;

    logic [31:0] pc_reg;
    logic        misalign_reg;
    logic [31:0] branch_offset;
    logic [31:0] target;
    logic        misalign_set;

    assign pc            = pc_reg;
    assign misalign_err  = misalign_reg;
    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign misalign_set  = (br_type == BR_JR) && (jr_target[1:0] != 2'b00);

    // Flag 2'b11 matches none of the comparisons below, so conditionals fall through untaken.
    always_comb begin
        branch_taken = 1'b0;
        case (br_type)
            BR_SEQ:  branch_taken = 1'b0;
            BR_BEQ:  branch_taken = (zero == FLAG_ZERO);
            BR_BNE:  branch_taken = (zero == FLAG_NEG) || (zero == FLAG_POS);
            BR_BGTZ: branch_taken = (zero == FLAG_POS);
            BR_BLEZ: branch_taken = (zero == FLAG_NEG) || (zero == FLAG_ZERO);
            BR_BLTZ: branch_taken = (zero == FLAG_NEG);
            BR_J:    branch_taken = 1'b1;
            BR_JR:   branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_plus4 + branch_offset;
        case (br_type)
            BR_J:    target = {pc_plus4[31:28], j_index, 2'b00};
            BR_JR:   target = {jr_target[31:2], 2'b00};
            default: target = pc_plus4 + branch_offset;
        endcase
    end

`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ds_state_t;

    ds_state_t   state_reg;
    logic [31:0] pending_target_reg;

    assign link_addr = pc_reg + 32'd8;

    // A redirect seen while PENDING sits in the delay slot and is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg             <= RESET_PC;
            misalign_reg       <= 1'b0;
            state_reg          <= IDLE;
            pending_target_reg <= 32'd0;
        end else if (!stall) begin
            if (misalign_set) begin
                misalign_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    pc_reg <= pc_plus4;
                    if (branch_taken) begin
                        pending_target_reg <= target;
                        state_reg          <= PENDING;
                    end
                end
                PENDING: begin
                    pc_reg    <= pending_target_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    pc_reg    <= pc_plus4;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
`else
    logic [31:0] pc_next;

    assign link_addr = pc_plus4;
    assign pc_next   = branch_taken ? target : pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            misalign_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg <= pc_next;
            if (misalign_set) begin
                misalign_reg <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit; expected values are hand-computed.
// Define BRANCH_DELAY_SLOT_EN for both bench and RTL to exercise the delay-slot build.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  br_type;
    logic [1:0]  zero;
    logic [15:0] imm16;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        branch_taken;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;

    branch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_type      (br_type),
        .zero         (zero),
        .imm16        (imm16),
        .j_index      (j_index),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_addr    (link_addr),
        .branch_taken (branch_taken),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-16s got=%08h", tag, got);
        end else begin
            $display("FAIL %-16s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Taken table per conditional type, bit index = zero flag value.
    logic [3:0] taken_tbl [1:5];

    initial begin
        taken_tbl[1] = 4'b0010;  // beq
        taken_tbl[2] = 4'b0101;  // bne
        taken_tbl[3] = 4'b0100;  // bgtz
        taken_tbl[4] = 4'b0011;  // blez
        taken_tbl[5] = 4'b0001;  // bltz

        reset = 1'b1; stall = 1'b1; br_type = 3'd0; zero = 2'b00;
        imm16 = 16'h0; j_index = 26'h0; jr_target = 32'h0;

        tick();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        tick();
        check("rst_pc2", pc, 32'h0000_3000);
        reset = 1'b0; stall = 1'b0;
        #1;

`ifdef BRANCH_DELAY_SLOT_EN
        br_type = 3'd1; zero = 2'b01; imm16 = 16'd7;  // 3004 + 28 = 3020
        #1;
        check("ds_beq_taken", {31'd0, branch_taken}, 32'd1);
        tick();
        check("ds_pc_slot", pc, 32'h0000_3004);
        br_type = 3'd6; j_index = 26'h0000100;
        #1;
        check("ds_j_reported", {31'd0, branch_taken}, 32'd1);
        stall = 1'b1;
        tick();
        tick();
        check("ds_stall_hold", pc, 32'h0000_3004);
        stall = 1'b0;
        tick();
        check("ds_pc_target", pc, 32'h0000_3020);
        br_type = 3'd0;
        tick();
        check("ds_j_ignored", pc, 32'h0000_3024);
        br_type = 3'd6;
        #1;
        check("ds_link", link_addr, 32'h0000_302C);
        check("ds_pc_plus4", pc_plus4, 32'h0000_3028);
        br_type = 3'd0;
`else
        check("pc_plus4", pc_plus4, 32'h0000_3004);
        check("link_addr", link_addr, 32'h0000_3004);
        check("seq_not_taken", {31'd0, branch_taken}, 32'd0);

        br_type = 3'd1; zero = 2'b01; imm16 = 16'hFFFE;
        #1;
        check("beq_taken", {31'd0, branch_taken}, 32'd1);
        tick();
        check("beq_pc", pc, 32'h0000_2FFC);

        br_type = 3'd0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_again", pc, 32'h0000_3000);
        br_type = 3'd1; zero = 2'b10; imm16 = 16'hFFFE;
        #1;
        check("beq_not_taken", {31'd0, branch_taken}, 32'd0);
        tick();
        check("beq_nt_pc", pc, 32'h0000_3004);

        // Flag sweep under stall so the PC stays put.
        stall = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            for (int z = 0; z < 4; z++) begin
                logic [3:0] row;
                row = taken_tbl[t];
                br_type = t[2:0];
                zero = z[1:0];
                #1;
                check($sformatf("sweep_t%0d_z%0d", t, z), {31'd0, branch_taken}, {31'd0, row[z]});
            end
        end
        br_type = 3'd6; #1;
        check("j_always", {31'd0, branch_taken}, 32'd1);
        br_type = 3'd7; #1;
        check("jr_always", {31'd0, branch_taken}, 32'd1);
        br_type = 3'd0;
        check("sweep_pc_hold", pc, 32'h0000_3004);
        tick();
        stall = 1'b0;
        tick();
        tick();
        tick();
        check("seq_pc", pc, 32'h0000_3010);

        br_type = 3'd6; j_index = 26'h0000C40;
        tick();
        check("j_pc", pc, 32'h0000_3100);

        br_type = 3'd7; jr_target = 32'h0000_3102;
        tick();
        check("jr_pc", pc, 32'h0000_3100);
        check("jr_misalign", {31'd0, misalign_err}, 32'd1);
        br_type = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sticky_%0d", i), {31'd0, misalign_err}, 32'd1);
        end
        check("sticky_pc", pc, 32'h0000_3114);

        br_type = 3'd7; jr_target = 32'hFFFF_FFFC;
        tick();
        check("jr_top_pc", pc, 32'hFFFF_FFFC);
        br_type = 3'd0;
        #1;
        check("wrap_plus4", pc_plus4, 32'h0000_0000);
        tick();
        check("wrap_pc", pc, 32'h0000_0000);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_clr_err", {31'd0, misalign_err}, 32'd0);
        check("rst_clr_pc", pc, 32'h0000_3000);

        br_type = 3'd1; zero = 2'b01; imm16 = 16'h0004; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc_%0d", i), pc, 32'h0000_3000);
        end
        check("stall_taken", {31'd0, branch_taken}, 32'd1);
        stall = 1'b0;
        tick();
        check("stall_release", pc, 32'h0000_3014);

        br_type = 3'd7; jr_target = 32'h0000_3101; stall = 1'b1;
        tick();
        check("stall_no_err", {31'd0, misalign_err}, 32'd0);
        check("stall_jr_pc", pc, 32'h0000_3014);

        stall = 1'b0; br_type = 3'd1; zero = 2'b01; imm16 = 16'h0004; reset = 1'b1;
        tick();
        reset = 1'b0; br_type = 3'd0;
        check("rst_beats_beq", pc, 32'h0000_3000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
